// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller:
// FSM states, funct3 branch encodings, ALU flag bit positions, defaults.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_FLAG = 2'd1,
    S_REDIRECT  = 2'd2
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLAG_EQ = 3;
  localparam int FLAG_LT = 2;

  localparam int XLEN_DEF         = 32;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF      = 15;

  localparam int CNT_W = 16;

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation: funct3 plus ALU eq/lt flags -> taken, illegal.
// Purely combinational; the signed/unsigned distinction lives in the ALU op.
module branch_cond
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lt,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:           taken = eq;
      F3_BNE:           taken = ~eq;
      F3_BLT, F3_BLTU:  taken = lt;
      F3_BGE, F3_BGEU:  taken = eq | ~lt;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: accepts one branch, waits for ALU flags, resolves it,
// issues redirect/flush on taken, and keeps saturating branch statistics.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic [3:0]      flag,
  input  logic            flag_valid,
  output logic            redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            flush,
  output logic            stall,
  output logic            br_err,
  input  logic            cnt_clr,
  output logic [15:0]     cnt_branch,
  output logic [15:0]     cnt_taken
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   pc_q, imm_q, target;
  logic [7:0]        tmo_q;
  logic [2:0]        fcnt_q;
  logic [CNT_W-1:0]  cnt_branch_q, cnt_taken_q;
  logic              taken, illegal;
  logic              accept, resolve, expire, take;
  logic              unused_flag;

  assign unused_flag = ^flag[1:0];

  branch_cond u_cond (
    .funct3  (funct3_q),
    .eq      (flag[FLAG_EQ]),
    .lt      (flag[FLAG_LT]),
    .taken   (taken),
    .illegal (illegal)
  );

  // flag_valid only matters once in WAIT_FLAG, so the capture cycle ignores it.
  assign accept  = br_valid && (state_q == S_IDLE);
  assign resolve = (state_q == S_WAIT_FLAG) && flag_valid;
  // The counter would reach zero on this flagless cycle: abort now.
  assign expire  = (state_q == S_WAIT_FLAG) && !flag_valid && (tmo_q == 8'd1);
  assign take    = resolve && taken;

  always_comb begin
    target    = pc_q + imm_q;
    target[0] = 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT_FLAG;
      end
      S_WAIT_FLAG: begin
        if (resolve)     state_d = take ? S_REDIRECT : S_IDLE;
        else if (expire) state_d = S_IDLE;
      end
      S_REDIRECT: begin
        if (fcnt_q == 3'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    br_ready = (state_q == S_IDLE);
    stall    = (state_q != S_IDLE);
    flush    = (state_q == S_REDIRECT);
    redirect = (state_q == S_REDIRECT) && (fcnt_q == FLUSH_LAST);
    br_err   = (resolve && illegal) || expire;
  end

  // Captured branch, timeout/flush timers and the redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q  <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      tmo_q     <= '0;
      fcnt_q    <= '0;
      pc_target <= '0;
    end else begin
      if (accept) begin
        funct3_q <= br_funct3;
        pc_q     <= br_pc;
        imm_q    <= br_imm;
        tmo_q    <= TMO_LOAD;
      end else if ((state_q == S_WAIT_FLAG) && !flag_valid) begin
        tmo_q <= tmo_q - 1'b1;
      end
      if (take) begin
        pc_target <= target;
        fcnt_q    <= FLUSH_LAST;
      end else if ((state_q == S_REDIRECT) && (fcnt_q != 3'd0)) begin
        fcnt_q <= fcnt_q - 1'b1;
      end
    end
  end

  // Performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
    end else if (cnt_clr) begin
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
    end else if (resolve && !illegal) begin
      cnt_branch_q <= sat_inc(cnt_branch_q);
      if (taken) cnt_taken_q <= sat_inc(cnt_taken_q);
    end
  end

  assign cnt_branch = cnt_branch_q;
  assign cnt_taken  = cnt_taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed + randomized bench for branch_ctrl against a transaction-level
// reference model (branch outcome, target, counters computed per branch).
module tb_branch_ctrl;
  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int TIMEOUT      = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            br_valid, br_ready;
  logic [2:0]      br_funct3;
  logic [XLEN-1:0] br_pc, br_imm, pc_target;
  logic [3:0]      flag;
  logic            flag_valid, redirect, flush, stall, br_err, cnt_clr;
  logic [15:0]     cnt_branch, cnt_taken;

  int n_assert = 0;
  int n_fail   = 0;

  int              exp_branch, exp_taken;
  logic [XLEN-1:0] exp_target;

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm), .flag(flag),
    .flag_valid(flag_valid), .redirect(redirect), .pc_target(pc_target),
    .flush(flush), .stall(stall), .br_err(br_err), .cnt_clr(cnt_clr),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [3:0] fl);
    bit eq, lt;
    eq = fl[3];
    lt = fl[2];
    case (f3)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return eq || !lt;
      default:        return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    exp_branch = 0;
    exp_taken  = 0;
    exp_target = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},    br_ready, 1);
    chk({tag, "_stall"},    stall, 0);
    chk({tag, "_redirect"}, redirect, 0);
    chk({tag, "_flush"},    flush, 0);
    chk({tag, "_err"},      br_err, 0);
    chk({tag, "_target"},   pc_target, exp_target);
    chk({tag, "_cnt_br"},   cnt_branch, 32'(exp_branch));
    chk({tag, "_cnt_tk"},   cnt_taken, 32'(exp_taken));
  endtask

  // One full branch transaction. delay = flagless WAIT_FLAG cycles before the flag.
  task automatic run_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                            input int delay, input logic [3:0] fl, input bit clr, input bit rst_mid);
    bit legal, tk, tmo;
    legal = ref_legal(f3);
    tk    = legal && ref_taken(f3, fl);
    tmo   = (delay >= TIMEOUT);

    @(negedge clk);
    chk("start_ready", br_ready, 1);
    br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_imm = imm;
    flag_valid = 1'b1; flag = ~fl;   // must be ignored in the capture cycle

    @(negedge clk);
    br_funct3 = 3'($urandom); br_pc = $urandom; br_imm = $urandom;  // br_valid stays high: not accepted
    chk("wait_ready", br_ready, 0);
    chk("wait_stall", stall, 1);
    for (int k = 0; k <= delay && k < TIMEOUT; k++) begin
      if (k > 0) @(negedge clk);
      if (k == delay) begin
        flag_valid = 1'b1; flag = fl; cnt_clr = clr;
      end else begin
        flag_valid = 1'b0; flag = 4'($urandom);
      end
      #1;
      chk("br_err", br_err, (k == delay) ? !legal : (k == TIMEOUT - 1));
      chk("wait_redirect", redirect, 0);
    end

    @(negedge clk);
    br_valid = 1'b0; flag_valid = 1'b0; cnt_clr = 1'b0;
    if (clr) begin
      exp_branch = 0; exp_taken = 0;
    end else if (!tmo && legal) begin
      if (exp_branch < 65535) exp_branch++;
      if (tk && exp_taken < 65535) exp_taken++;
    end
    if (!tmo && tk) exp_target = (pc + imm) & ~32'd1;

    if (!tmo && tk) begin
      for (int c = 0; c < FLUSH_CYCLES; c++) begin
        if (c > 0) @(negedge clk);
        chk("redirect", redirect, (c == 0));
        chk("flush", flush, 1);
        chk("redir_stall", stall, 1);
        chk("redir_target", pc_target, exp_target);
        if (rst_mid) begin
          rst_n = 1'b0;
          #1;
          model_reset();
          chk("rst_flush", flush, 0);
          chk("rst_stall", stall, 0);
          chk("rst_ready", br_ready, 1);
          chk("rst_redirect", redirect, 0);
          chk("rst_target", pc_target, 0);
          chk("rst_cnt_tk", cnt_taken, 0);
          @(negedge clk);
          rst_n = 1'b1;
          break;
        end
      end
    end else begin
      chk("nt_ready", br_ready, 1);
      chk("nt_redirect", redirect, 0);
      chk("nt_flush", flush, 0);
    end

    @(negedge clk);
    chk_idle("post");
  endtask

  initial begin
    br_valid = 1'b0; br_funct3 = '0; br_pc = '0; br_imm = '0;
    flag = '0; flag_valid = 1'b0; cnt_clr = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // beq taken: 0x100 + 0x20
    run_branch(3'b000, 32'h100, 32'h20, 0, 4'b1000, 0, 0);
    // bge not taken on lt without eq
    run_branch(3'b101, 32'h200, 32'h40, 0, 4'b0100, 0, 0);
    // illegal funct3
    run_branch(3'b010, 32'h300, 32'h8, 0, 4'b1000, 0, 0);
    run_branch(3'b011, 32'h300, 32'h8, 2, 4'b0000, 0, 0);
    // timeout, and flag arriving on the last allowed cycle
    run_branch(3'b000, 32'h400, 32'h10, 20, 4'b1000, 0, 0);
    run_branch(3'b001, 32'h500, 32'h10, TIMEOUT - 1, 4'b0000, 0, 0);
    // odd target gets bit 0 cleared; address wraparound; negative offset
    run_branch(3'b100, 32'h1001, 32'h2, 1, 4'b0100, 0, 0);
    run_branch(3'b111, 32'hFFFF_FFF0, 32'h20, 0, 4'b1100, 0, 0);
    run_branch(3'b110, 32'h800, 32'hFFFF_FF00, 3, 4'b0110, 0, 0);

    for (int i = 0; i < 40; i++)
      run_branch(3'($urandom), $urandom, $urandom, int'($urandom_range(0, 17)),
                 4'($urandom), ($urandom_range(0, 7) == 0), 0);

    // Saturation: preload both counters just below the top.
    @(negedge clk);
    force dut.cnt_taken_q  = 16'hFFFE;
    force dut.cnt_branch_q = 16'hFFFE;
    #1;
    release dut.cnt_taken_q;
    release dut.cnt_branch_q;
    exp_branch = 65534;
    exp_taken  = 65534;
    run_branch(3'b000, 32'h40, 32'h4, 0, 4'b1000, 0, 0);
    run_branch(3'b000, 32'h44, 32'h4, 1, 4'b1000, 0, 0);
    run_branch(3'b001, 32'h48, 32'h4, 0, 4'b1000, 0, 0);
    // Clear coinciding with a taken increment
    run_branch(3'b001, 32'h50, 32'h8, 0, 4'b0000, 1, 0);
    run_branch(3'b000, 32'h60, 32'h8, 0, 4'b1000, 0, 0);
    // Reset during the first flush cycle, then normal operation resumes
    run_branch(3'b000, 32'h700, 32'h100, 0, 4'b1000, 0, 1);
    run_branch(3'b101, 32'h900, 32'h10, 0, 4'b1000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
